// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin I/D arbiter sequencing one single-port memory
// Each granted request becomes one strobe, a bounded wait for MemAck, and a one-cycle Ack/Err.
module memory_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IReq,
    input  logic [31:0]      IAddress,
    output logic             IAck,
    output logic             IErr,
    output logic [WIDTH-1:0] IData,
    input  logic             DReq,
    input  logic             DWrite,
    input  logic [31:0]      DAddress,
    input  logic [WIDTH-1:0] DWriteData,
    output logic             DAck,
    output logic             DErr,
    output logic [WIDTH-1:0] DReadData,
    output logic             MemReadEnable,
    output logic             MemWriteEnable,
    output logic [31:0]      MemAddress,
    output logic [WIDTH-1:0] MemWriteData,
    input  logic             MemAck,
    input  logic [WIDTH-1:0] MemReadData,
    output logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_grant_d;
    logic       r_last_grant_d;
    logic       r_write;
    logic [7:0] r_timer;

    logic       w_grant_valid;
    logic       w_grant_d;
    logic       w_grant_write;
    logic       w_mem_done;
    logic       w_timeout;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Ties go to whichever port did not win last; a lone request always wins.
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_d     = 1'b0;
        w_mem_done    = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (IReq && DReq) begin
                    w_grant_valid = 1'b1;
                    w_grant_d     = ~r_last_grant_d;
                end else if (DReq) begin
                    w_grant_valid = 1'b1;
                    w_grant_d     = 1'b1;
                end else if (IReq) begin
                    w_grant_valid = 1'b1;
                    w_grant_d     = 1'b0;
                end
                if (w_grant_valid) begin
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (MemAck) begin
                    w_mem_done   = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_timer == TIMEOUT_L) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_grant_write = w_grant_d & DWrite;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_grant_d      <= 1'b0;
            r_last_grant_d <= 1'b0;
            r_write        <= 1'b0;
            r_timer        <= 8'd0;
            IAck           <= 1'b0;
            IErr           <= 1'b0;
            IData          <= '0;
            DAck           <= 1'b0;
            DErr           <= 1'b0;
            DReadData      <= '0;
            MemReadEnable  <= 1'b0;
            MemWriteEnable <= 1'b0;
            MemAddress     <= 32'd0;
            MemWriteData   <= '0;
            Busy           <= 1'b0;
        end else begin
            Busy <= (w_next_state != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_grant_d      <= w_grant_d;
                        r_last_grant_d <= w_grant_d;
                        r_write        <= w_grant_write;
                        MemAddress     <= w_grant_d ? DAddress : IAddress;
                        MemWriteData   <= w_grant_write ? DWriteData : '0;
                        MemReadEnable  <= ~w_grant_write;
                        MemWriteEnable <= w_grant_write;
                    end
                end
                S_ISSUE: begin
                    MemReadEnable  <= 1'b0;
                    MemWriteEnable <= 1'b0;
                    r_timer        <= 8'd0;
                end
                S_WAIT: begin
                    // Stores return zero data; a timeout returns zero data with Err.
                    if (w_mem_done) begin
                        if (r_grant_d) begin
                            DAck      <= 1'b1;
                            DErr      <= 1'b0;
                            DReadData <= r_write ? '0 : MemReadData;
                        end else begin
                            IAck  <= 1'b1;
                            IErr  <= 1'b0;
                            IData <= MemReadData;
                        end
                    end else if (w_timeout) begin
                        if (r_grant_d) begin
                            DAck      <= 1'b1;
                            DErr      <= 1'b1;
                            DReadData <= '0;
                        end else begin
                            IAck  <= 1'b1;
                            IErr  <= 1'b1;
                            IData <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_RESP: begin
                    IAck      <= 1'b0;
                    IErr      <= 1'b0;
                    IData     <= '0;
                    DAck      <= 1'b0;
                    DErr      <= 1'b0;
                    DReadData <= '0;
                end
                default: begin
                    MemReadEnable  <= 1'b0;
                    MemWriteEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule
